// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. It merges the ALU writeback port (A), which cannot
// be stalled, with a buffered load/multiply port (B) onto one registered write port.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        reg_write,
    output logic [4:0]  write_register,
    output logic [31:0] data_to_write,
    input  logic [4:0]  query_rs1,
    input  logic [4:0]  query_rs2,
    output logic        rs1_hazard,
    output logic        rs2_hazard,
    output logic        stall_req,
    output logic        drop_err
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // Two-entry FIFO kept as a shift register: entry 0 is always the head.
    logic [1:0]        r_valid;
    logic [1:0]        r_squash;
    logic [1:0][4:0]   r_rd;
    logic [1:0][31:0]  r_data;
    logic [CW-1:0]     r_starve;
    logic              r_stall;
    logic              r_drop;
    logic              r_regWrite;
    logic [4:0]        r_wr;
    logic [31:0]       r_wd;

    logic [1:0]        w_count;
    logic              w_bAccept;
    logic              w_enq;
    logic              w_aReq;
    logic              w_aWin;
    logic              w_pop;
    logic              w_drop;
    logic [1:0]        w_nValid;
    logic [1:0]        w_nSquash;
    logic [1:0][4:0]   w_nRd;
    logic [1:0][31:0]  w_nData;
    logic [CW-1:0]     w_starveNext;

    assign w_count   = {r_valid[0] & r_valid[1], r_valid[0] ^ r_valid[1]};
    assign b_ready   = ~w_count[1];
    assign w_bAccept = b_valid & b_ready;
    assign w_enq     = w_bAccept & (b_rd != 5'd0);
    assign w_aReq    = a_valid & (a_rd != 5'd0);
    assign w_aWin    = w_aReq & ~r_stall;
    assign w_pop     = ~w_aWin & r_valid[0];
    assign w_drop    = w_aReq & r_stall;

    // Squash only entries already queued; a same-cycle enqueue is younger than A.
    always_comb begin
        w_nValid  = r_valid;
        w_nSquash = r_squash;
        w_nRd     = r_rd;
        w_nData   = r_data;
        if (w_aWin) begin
            for (int i = 0; i < 2; i++) begin
                if (r_valid[i] && (r_rd[i] == a_rd)) w_nSquash[i] = 1'b1;
            end
        end
        if (w_pop) begin
            w_nValid   = {1'b0, r_valid[1]};
            w_nSquash  = {1'b0, r_squash[1]};
            w_nRd[0]   = r_rd[1];
            w_nData[0] = r_data[1];
        end
        if (w_enq) begin
            if (w_nValid[0]) begin
                w_nValid[1]  = 1'b1;
                w_nSquash[1] = 1'b0;
                w_nRd[1]     = b_rd;
                w_nData[1]   = b_data;
            end else begin
                w_nValid[0]  = 1'b1;
                w_nSquash[0] = 1'b0;
                w_nRd[0]     = b_rd;
                w_nData[0]   = b_data;
            end
        end
    end

    always_comb begin
        w_starveNext = r_starve;
        if (w_pop || !r_valid[0]) begin
            w_starveNext = '0;
        end else if (w_aWin && (r_starve != LIMIT)) begin
            w_starveNext = r_starve + 1'b1;
        end
    end

    function automatic logic hazardFor(input logic [4:0] q);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (r_valid[i] && !r_squash[i] && (r_rd[i] == q)) hit = 1'b1;
        end
        if (w_bAccept && (b_rd == q)) hit = 1'b1;
        if (r_regWrite && (r_wr == q)) hit = 1'b1;
        return reset_n && (q != 5'd0) && hit;
    endfunction

    always_comb begin
        rs1_hazard = hazardFor(query_rs1);
        rs2_hazard = hazardFor(query_rs2);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= '0;
            r_squash   <= '0;
            r_rd       <= '0;
            r_data     <= '0;
            r_starve   <= '0;
            r_stall    <= 1'b0;
            r_drop     <= 1'b0;
            r_regWrite <= 1'b0;
            r_wr       <= '0;
            r_wd       <= '0;
        end else begin
            r_valid  <= w_nValid;
            r_squash <= w_nSquash;
            r_rd     <= w_nRd;
            r_data   <= w_nData;
            r_starve <= w_starveNext;
            r_stall  <= (w_starveNext == LIMIT);
            if (w_drop) r_drop <= 1'b1;
            if (w_aWin) begin
                r_regWrite <= 1'b1;
                r_wr       <= a_rd;
                r_wd       <= a_data;
            end else if (w_pop) begin
                r_regWrite <= ~r_squash[0];
                r_wr       <= r_rd[0];
                r_wd       <= r_data[0];
            end else begin
                r_regWrite <= 1'b0;
            end
        end
    end

    assign reg_write      = r_regWrite;
    assign write_register = r_wr;
    assign data_to_write  = r_wd;
    assign stall_req      = r_stall;
    assign drop_err       = r_drop;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed corner-case
// sequences and a random run, all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int STARVE_LIMIT = 3;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] data_to_write;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        rs1_hazard;
    logic        rs2_hazard;
    logic        stall_req;
    logic        drop_err;

    regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .reg_write(reg_write), .write_register(write_register), .data_to_write(data_to_write),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
        .stall_req(stall_req), .drop_err(drop_err)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    // Reference model: pending B writes in arrival order plus the observable flags.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          squash;
    } entry_t;
    entry_t      mq[$];
    int          mStarve;
    bit          mStall, mDrop, mRegWrite;
    logic [4:0]  mWr;
    logic [31:0] mData;

    logic [31:0] shadowRegs [32];
    int          shadowWrites [32];
    logic        lastBReady, lastStall, lastH1, lastH2;

    typedef struct {
        logic        aV;
        logic [4:0]  aRd;
        logic [31:0] aData;
        logic        bV;
        logic [4:0]  bRd;
        logic [31:0] bData;
        logic        expReady;
        logic        expRw;
        logic [4:0]  expWr;
        logic [31:0] expData;
    } vec_t;
    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit modelHazard(input logic [4:0] q, input bit accept, input logic [4:0] bRdIn);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (!mq[i].squash && mq[i].rd == q) return 1'b1;
        if (accept && bRdIn == q) return 1'b1;
        if (mRegWrite && mWr == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clearShadow();
        for (int i = 0; i < 32; i++) begin
            shadowRegs[i] = 32'd0;
            shadowWrites[i] = 0;
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, step the model at the edge, check registered outputs.
    task automatic applyStimulus(input logic aV, input logic [4:0] aRdIn, input logic [31:0] aD,
                                 input logic bV, input logic [4:0] bRdIn, input logic [31:0] bD,
                                 input logic [4:0] q1, input logic [4:0] q2);
        bit     expReady, accept, aReq;
        entry_t head;
        @(negedge clk_in);
        a_valid = aV; a_rd = aRdIn; a_data = aD;
        b_valid = bV; b_rd = bRdIn; b_data = bD;
        query_rs1 = q1; query_rs2 = q2;
        #1;
        expReady = (mq.size() < 2);
        accept   = bV && expReady;
        aReq     = aV && (aRdIn != 5'd0);
        lastBReady = b_ready; lastStall = stall_req; lastH1 = rs1_hazard; lastH2 = rs2_hazard;
        checkOutput("b_ready", b_ready, expReady);
        checkOutput("rs1_hazard", rs1_hazard, modelHazard(q1, accept, bRdIn));
        checkOutput("rs2_hazard", rs2_hazard, modelHazard(q2, accept, bRdIn));
        @(posedge clk_in);
        if (aReq && !mStall) begin
            foreach (mq[i]) if (mq[i].rd == aRdIn) mq[i].squash = 1'b1;
            if (mq.size() == 0) mStarve = 0;
            else if (mStarve < STARVE_LIMIT) mStarve++;
            mRegWrite = 1'b1; mWr = aRdIn; mData = aD;
        end else begin
            if (aReq) mDrop = 1'b1;
            if (mq.size() != 0) begin
                head = mq.pop_front();
                mRegWrite = !head.squash; mWr = head.rd; mData = head.data;
            end else begin
                mRegWrite = 1'b0;
            end
            mStarve = 0;
        end
        if (accept && bRdIn != 5'd0) mq.push_back('{rd: bRdIn, data: bD, squash: 1'b0});
        mStall = (mStarve == STARVE_LIMIT);
        #1;
        checkOutput("reg_write", reg_write, mRegWrite);
        if (mRegWrite) begin
            checkOutput("write_register", write_register, mWr);
            checkOutput("data_to_write", data_to_write, mData);
        end
        checkOutput("stall_req", stall_req, mStall);
        checkOutput("drop_err", drop_err, mDrop);
        if (reg_write === 1'b1) begin
            shadowRegs[write_register] = data_to_write;
            shadowWrites[write_register]++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asserts reset immediately; B is offered with a matching query to prove hazards stay low.
    task automatic resetDut();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 1; b_rd = 5'd5; b_data = 32'h5;
        query_rs1 = 5'd5; query_rs2 = 5'd5;
        reset_n = 0;
        #1;
        checkOutput("rst b_ready", b_ready, 1'b1);
        checkOutput("rst reg_write", reg_write, 1'b0);
        checkOutput("rst rs1_hazard", rs1_hazard, 1'b0);
        checkOutput("rst rs2_hazard", rs2_hazard, 1'b0);
        checkOutput("rst stall_req", stall_req, 1'b0);
        checkOutput("rst drop_err", drop_err, 1'b0);
        repeat (2) @(posedge clk_in);
        b_valid = 0; query_rs1 = 0; query_rs2 = 0;
        #2;
        reset_n = 1;
        mq.delete();
        mStarve = 0; mStall = 0; mDrop = 0; mRegWrite = 0; mWr = 0; mData = 0;
    endtask

    initial begin
        vecs[0]  = '{1, 5'd5,  32'h11,  0, 5'd0,  32'h0,    1, 1, 5'd5,  32'h11};
        vecs[1]  = '{0, 5'd0,  32'h0,   1, 5'd7,  32'hAA,   1, 0, 5'd0,  32'h0};
        vecs[2]  = '{0, 5'd0,  32'h0,   1, 5'd8,  32'hBB,   1, 1, 5'd7,  32'hAA};
        vecs[3]  = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,    1, 1, 5'd8,  32'hBB};
        vecs[4]  = '{1, 5'd1,  32'h100, 1, 5'd20, 32'hC1,   1, 1, 5'd1,  32'h100};
        vecs[5]  = '{1, 5'd2,  32'h200, 1, 5'd21, 32'hC2,   1, 1, 5'd2,  32'h200};
        vecs[6]  = '{1, 5'd0,  32'h300, 1, 5'd22, 32'hC3,   0, 1, 5'd20, 32'hC1};
        vecs[7]  = '{0, 5'd0,  32'h0,   1, 5'd22, 32'hC3,   1, 1, 5'd21, 32'hC2};
        vecs[8]  = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,    1, 1, 5'd22, 32'hC3};
        vecs[9]  = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,    1, 0, 5'd0,  32'h0};
        vecs[10] = '{0, 5'd0,  32'h0,   1, 5'd0,  32'hDEAD, 1, 0, 5'd0,  32'h0};
        vecs[11] = '{0, 5'd0,  32'h0,   0, 5'd0,  32'h0,    1, 0, 5'd0,  32'h0};

        reset_n = 1;
        a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
        query_rs1 = 0; query_rs2 = 0;
        clearShadow();
        #3;
        resetDut();

        // Vector table; the first vector also lands on the first edge after reset release.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].aV, vecs[i].aRd, vecs[i].aData,
                          vecs[i].bV, vecs[i].bRd, vecs[i].bData, 0, 0);
            checkOutput($sformatf("vec%0d b_ready", i), lastBReady, vecs[i].expReady);
            checkOutput($sformatf("vec%0d reg_write", i), reg_write, vecs[i].expRw);
            if (vecs[i].expRw) begin
                checkOutput($sformatf("vec%0d write_register", i), write_register, vecs[i].expWr);
                checkOutput($sformatf("vec%0d data_to_write", i), data_to_write, vecs[i].expData);
            end
        end

        // WAW squash of an older queued write, and a same-cycle younger enqueue that survives.
        resetDut();
        clearShadow();
        applyStimulus(0, 0, 0, 1, 5'd3, 32'h1, 0, 0);
        applyStimulus(1, 5'd3, 32'h2, 0, 0, 0, 0, 0);
        checkOutput("waw A write data", data_to_write, 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("waw squashed pop", reg_write, 1'b0);
        idle(1);
        checkOutput("waw final reg3", shadowRegs[3], 32'h2);
        applyStimulus(0, 0, 0, 1, 5'd4, 32'h10, 0, 0);
        applyStimulus(1, 5'd4, 32'h20, 1, 5'd4, 32'h30, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("young squashed pop", reg_write, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("young survives rw", reg_write, 1'b1);
        checkOutput("young final reg4", shadowRegs[4], 32'h30);

        // Starvation: three A wins over a nonempty FIFO raise stall; the next A is dropped.
        resetDut();
        applyStimulus(0, 0, 0, 1, 5'd10, 32'hA0, 0, 0);
        applyStimulus(1, 5'd13, 32'h13, 0, 0, 0, 0, 0);
        checkOutput("starve c2 stall", stall_req, 1'b0);
        applyStimulus(1, 5'd14, 32'h14, 0, 0, 0, 0, 0);
        checkOutput("starve c3 stall", stall_req, 1'b0);
        applyStimulus(1, 5'd15, 32'h15, 0, 0, 0, 0, 0);
        checkOutput("starve c4 stall", stall_req, 1'b1);
        applyStimulus(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
        checkOutput("drop cycle stall", lastStall, 1'b1);
        checkOutput("drop head wr", write_register, 5'd10);
        checkOutput("drop head data", data_to_write, 32'hA0);
        checkOutput("drop_err set", drop_err, 1'b1);
        checkOutput("stall released", stall_req, 1'b0);
        applyStimulus(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
        checkOutput("after drop wr", write_register, 5'd9);
        checkOutput("drop_err sticky", drop_err, 1'b1);

        // Hazard tracking through accept, FIFO residency and the write stage.
        resetDut();
        applyStimulus(0, 0, 0, 1, 5'd12, 32'h12, 5'd12, 5'd0);
        checkOutput("haz accept rs1", lastH1, 1'b1);
        applyStimulus(1, 5'd1, 32'h1, 0, 0, 0, 5'd12, 5'd0);
        checkOutput("haz fifo rs1", lastH1, 1'b1);
        checkOutput("haz fifo rs2", lastH2, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd12, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd12, 5'd0);
        checkOutput("haz write stage rs1", lastH1, 1'b1);
        applyStimulus(1, 5'd12, 32'h77, 0, 0, 0, 5'd12, 5'd0);
        checkOutput("haz ignores A rs1", lastH1, 1'b0);

        // Random traffic against the model.
        resetDut();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        // Mid-cycle reset with two queued writes: nothing may be written afterwards.
        resetDut();
        applyStimulus(1, 5'd1, 32'h1, 1, 5'd25, 32'h25, 0, 0);
        applyStimulus(1, 5'd2, 32'h2, 1, 5'd26, 32'h26, 0, 0);
        checkOutput("full before reset", b_ready, 1'b0);
        #2;
        resetDut();
        clearShadow();
        idle(4);
        checkOutput("no write rd25", shadowWrites[25], 0);
        checkOutput("no write rd26", shadowWrites[26], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3, meaning the number of consecutive cycles A may win while FIFO holds data before stall_req asserts.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock, rising edge active.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports a_valid (in, 1), a_rd (in, 5) and a_data (in, 32): the single-cycle ALU writeback, which cannot be backpressured.
REQ-005 The block SHALL have ports b_valid (in, 1), b_ready (out, 1), b_rd (in, 5) and b_data (in, 32): the multi-cycle load/multiply writeback, with a valid/ready handshake.
REQ-006 The block SHALL have ports reg_write (out, 1), write_register (out, 5) and data_to_write (out, 32): the register-file write port, all registered.
REQ-007 The block SHALL have ports query_rs1 (in, 5) and query_rs2 (in, 5): the decode-stage source registers.
REQ-008 The block SHALL have ports rs1_hazard (out, 1) and rs2_hazard (out, 1): combinational RAW-hazard flags.
REQ-009 The block SHALL have port stall_req, out, 1 bit: registered; while it is 1, upstream must hold a_valid=0.
REQ-010 The block SHALL have port drop_err, out, 1 bit: sticky flag, set when an A write is lost.

Function
REQ-011 The block SHALL hold B writes in a 2-entry FIFO; each entry holds {valid, squash, rd, data}.
REQ-012 The block SHALL drive b_ready=1 whenever FIFO count<2; this is combinational from count only.
REQ-013 A B transfer (b_valid & b_ready) with b_rd=0 SHALL complete the handshake but SHALL NOT enqueue.
REQ-014 An A request with a_rd=0 SHALL be ignored: no write, no arbitration win, no squash.
REQ-015 Arbitration each cycle SHALL be: if stall_req=0 and A is valid with a nonzero rd, A wins; else if the FIFO is nonempty, pop the head; else idle.
REQ-016 The winner SHALL appear on reg_write/write_register/data_to_write at the next rising edge (1-cycle latency); idle cycles SHALL drive reg_write=0.
REQ-017 A popped entry with squash=1 SHALL be discarded with reg_write=0; the pop still consumes that cycle.
REQ-018 When A wins with rd X, every FIFO entry with rd=X SHALL have squash set (WAW protection); an entry enqueued in the same cycle with rd X SHALL NOT be squashed, because it is younger.
REQ-019 Simultaneous enqueue and pop when the FIFO is full SHALL NOT occur, because b_ready=0; enqueue and pop together at count 1 SHALL leave count 1.
REQ-020 Starvation counter: it SHALL increment when A wins while the FIFO is nonempty, and clear on any FIFO pop or when the FIFO is empty; it saturates at STARVE_LIMIT.
REQ-021 stall_req SHALL go to 1 at the edge after the counter reaches STARVE_LIMIT, and return to 0 at the edge after the next pop.
REQ-022 If a_valid=1 with a_rd≠0 while stall_req=1, the A write SHALL be dropped and drop_err SHALL be set; drop_err clears only on reset.
REQ-023 rsN_hazard SHALL be 1 when query_rsN≠0 and it matches any of:
- the rd of a valid, unsquashed FIFO entry;
- b_rd of a B transfer accepted this cycle;
- write_register while reg_write=1.
REQ-024 Hazard outputs SHALL NOT depend on a_valid or a_rd.

Reset
REQ-025 While reset_n=0, the block SHALL asynchronously clear all of the following: FIFO (count 0, entries invalid), reg_write, write_register, data_to_write, stall_req, drop_err, and the starvation counter.
REQ-026 While reset_n=0, b_ready SHALL read 1 and hazard outputs SHALL read 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending FIFO writes, with no write issued afterward.
REQ-028 After reset_n rises, the first arbitration SHALL occur on the first rising edge.

Verification
REQ-029 Bench: A-only: a_valid=1, a_rd=5, a_data=0x11 -> next cycle reg_write=1, write_register=5, data_to_write=0x11.
REQ-030 Bench: B enqueues rd=7, data=0xAA, then rd=8, data=0xBB, with a_valid=0 -> writes to 7 then 8 on consecutive cycles; b_ready=0 only while count=2.
REQ-031 Bench: FIFO holds rd=3, data=0x1; A writes rd=3, data=0x2 -> output writes 0x2 to 3, the later pop gives reg_write=0, and the final Register[3]=0x2.
REQ-032 Bench: FIFO nonempty plus A writing 3 consecutive cycles -> stall_req=1 on the 4th cycle; A asserted with rd 9 in that cycle -> drop_err=1 and the FIFO head is written.
REQ-033 Bench: FIFO entry rd=12; query_rs1=12, query_rs2=0 -> rs1_hazard=1, rs2_hazard=0; after the pop write completes -> rs1_hazard=0.
REQ-034 Bench: reset_n pulsed low mid-cycle with 2 FIFO entries -> immediate reg_write=0 and b_ready=1, and no write to those rds afterward.
